// File: rtl/mips_int_ctrl.sv
// Vectored interrupt controller: synchronised edge/level channels, fixed lowest-index priority.
// Build option: define INT_NESTING_EN to let strictly higher-priority channels preempt service.
module mips_int_ctrl #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irq,
    output logic                       int_req,
    input  logic                       int_ack,
    input  logic                       int_eoi,
    output logic [$clog2(NUM_IRQ)-1:0] int_id,
    output logic [31:0]                int_vec,
    input  logic                       cfg_we,
    input  logic                       cfg_sel,
    input  logic [NUM_IRQ-1:0]         cfg_wdata,
    output logic [NUM_IRQ-1:0]         pending
);
    localparam int unsigned IdW = $clog2(NUM_IRQ);
    localparam logic [NUM_IRQ-1:0] One = {{(NUM_IRQ-1){1'b0}}, 1'b1};

    typedef logic [NUM_IRQ-1:0] vec_t;

    // One-hot of the lowest set bit (highest priority), zero if none.
    function automatic vec_t lowest(input vec_t v);
        return v & (~v + One);
    endfunction

    // Channels permitted to request while the given in-service set is active.
    function automatic vec_t allowed(input vec_t in_svc);
`ifdef INT_NESTING_EN
        return lowest(in_svc) - One;
`else
        return (in_svc == '0) ? '1 : '0;
`endif
    endfunction

    function automatic logic [IdW-1:0] onehot_id(input vec_t oh);
        logic [IdW-1:0] id;
        id = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (oh[i]) id = IdW'(i);
        end
        return id;
    endfunction

    vec_t           sync1_q, sync2_q, sync3_q;
    vec_t           mask_q, mask_d, mode_q, mode_d;
    vec_t           pending_q, pending_d, in_service_q, in_service_d;
    logic           int_req_q, int_req_d;
    logic [IdW-1:0] int_id_q, int_id_d;
    vec_t           rise, eligible, in_service_eoi, ack_pool, ack_oh, ack_clr;
    logic           ack_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            mask_q       <= '1;
            mode_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
        end else begin
            sync1_q      <= irq;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
        end
    end

    always_comb begin
        rise     = sync2_q & ~sync3_q;
        eligible = pending_q & ~mask_q & ~in_service_q;

        // EOI retires first so a same-cycle ack sees the updated in-service set.
        in_service_eoi = in_service_q;
        if (int_eoi) in_service_eoi = in_service_q & ~lowest(in_service_q);

        ack_pool = pending_q & ~mask_q & ~in_service_eoi & allowed(in_service_eoi);
        ack_oh   = lowest(ack_pool);
        ack_take = int_ack && int_req_q && (ack_pool != '0);
        ack_clr  = ack_take ? ack_oh : '0;

        in_service_d = in_service_eoi | ack_clr;
        // Edge channels: a new rise beats a same-cycle ack clear. Level channels track the line.
        pending_d = (mode_q & ((pending_q & ~ack_clr) | rise)) | (~mode_q & sync2_q);
        int_req_d = !ack_take && ((eligible & allowed(in_service_q)) != '0);

        int_id_d = int_id_q;
        if (ack_take) begin
            int_id_d = onehot_id(ack_oh);
        end else if ((in_service_eoi != in_service_q) && (in_service_eoi != '0)) begin
            int_id_d = onehot_id(lowest(in_service_eoi));
        end

        mask_d = mask_q;
        mode_d = mode_q;
        if (cfg_we) begin
            if (cfg_sel) mode_d = cfg_wdata;
            else         mask_d = cfg_wdata;
        end
    end

    assign int_req = int_req_q;
    assign int_id  = int_id_q;
    assign pending = pending_q;
    assign int_vec = VEC_BASE + 32'(int_id_q) * VEC_STRIDE;

endmodule
